// File: rtl/xilinx_fifo_sync_reader.sv
// Read-side adapter for the synchronous FIFO macro in standard (non-FWFT) mode.
// Issues RDEN, absorbs the 1+DO_REG read latency and presents a valid/ready stream.
//
// Ports:
//   CLK, RST         clock and asynchronous active-high reset (shared with macro)
//   FIFO_EMPTY       macro EMPTY
//   FIFO_DO          macro DO
//   FIFO_RDERR       macro RDERR
//   FIFO_RDEN        macro RDEN
//   M_VALID          stream valid (buffer not empty)
//   M_READY          stream consumer ready
//   M_DATA           stream data (buffer head)
//   OCCUPANCY        words held in the output buffer
//   RDERR_STICKY     latched FIFO_RDERR, cleared only by RST
module xilinx_fifo_sync_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int DO_REG     = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_DO,
  input  logic                  FIFO_RDERR,
  output logic                  FIFO_RDEN,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [1:0]            OCCUPANCY,
  output logic                  RDERR_STICKY
);

  localparam int LAT       = 1 + DO_REG;
  localparam int BUF_DEPTH = LAT + 1;

  localparam logic [2:0] DEPTH_W  = 3'(BUF_DEPTH);
  localparam logic [1:0] DEPTH_O  = 2'(BUF_DEPTH);
  localparam logic [1:0] PTR_LAST = 2'(BUF_DEPTH - 1);

  logic [LAT-1:0]        vld;
  logic [LAT:0]          chain;
  logic [2:0]            inflight;
  logic [2:0]            budget;
  logic                  capture;
  logic                  pop;
  logic [1:0]            wp;
  logic [1:0]            rp;
  // Four slots keep the 2-bit pointers a clean index; only
  // BUF_DEPTH of them are ever addressed.
  logic [DATA_WIDTH-1:0] mem [4];

  assign capture = vld[LAT-1];
  assign M_VALID = (OCCUPANCY != 2'd0);
  assign pop     = M_VALID & M_READY;
  assign M_DATA  = mem[rp];

  always_comb begin
    inflight = 3'd0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + {2'b00, vld[i]};
    end
  end

  // Words the buffer will have to hold once everything in
  // flight lands, net of the word leaving this cycle.
  assign budget = {1'b0, OCCUPANCY} + inflight
                - {2'b00, pop};

  assign FIFO_RDEN = !RST && !FIFO_EMPTY
                  && (budget < DEPTH_W);

  assign chain = {vld, FIFO_RDEN};

  // Depth 3 is not a power of two, so wrap explicitly.
  function automatic logic [1:0] inc(
    input logic [1:0] p
  );
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld          <= '0;
      wp           <= '0;
      rp           <= '0;
      OCCUPANCY    <= '0;
      RDERR_STICKY <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else begin
      vld <= chain[LAT-1:0];
      if (capture) begin
        mem[wp] <= FIFO_DO;
        wp      <= inc(wp);
      end
      if (pop) begin
        rp <= inc(rp);
      end
      case ({capture, pop})
        2'b10:   OCCUPANCY <= OCCUPANCY + 2'd1;
        2'b01:   OCCUPANCY <= OCCUPANCY - 2'd1;
        default: OCCUPANCY <= OCCUPANCY;
      endcase
      if (FIFO_RDERR) begin
        RDERR_STICKY <= 1'b1;
      end
    end
  end

  // The issue rule guarantees a free slot for every landing word.
  a_no_overflow : assert property (
    @(posedge CLK) disable iff (RST)
    !(capture && !pop && (OCCUPANCY == DEPTH_O))
  );

endmodule

// File: tb/tb_xilinx_fifo_sync_reader.sv
// Bench for xilinx_fifo_sync_reader: two instances (DO_REG=0 and 1)
// driven by behavioural FIFO macro models, checked through a scoreboard.
module tb_xilinx_fifo_sync_reader;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          e0, e1, rden0, rden1;
  logic          v0, v1, rdy0, rdy1;
  logic          re0, re1, st0, st1;
  logic          force_err;
  logic [DW-1:0] do0, do1, md0, md1;
  logic [1:0]    oc0, oc1;

  logic [DW-1:0] fm0 [64];
  logic [DW-1:0] fm1 [64];
  int            wr0, wr1, rd0, rd1;
  logic [DW-1:0] dl0, dl1, dr1;
  logic          er0, er1;

  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int            n_chk, n_fail, n_del1;

  assign e0  = (rd0 == wr0);
  assign e1  = (rd1 == wr1);
  assign do0 = dl0;
  assign do1 = dr1;
  assign re0 = er0;
  assign re1 = er1 | force_err;

  always @(posedge clk) begin
    if (rst) begin
      rd0 <= 0;
      rd1 <= 0;
      er0 <= 1'b0;
      er1 <= 1'b0;
    end else begin
      er0 <= rden0 && e0;
      er1 <= rden1 && e1;
      if (rden0 && !e0) begin
        dl0 <= fm0[rd0[5:0]];
        rd0 <= rd0 + 1;
      end
      if (rden1 && !e1) begin
        dl1 <= fm1[rd1[5:0]];
        rd1 <= rd1 + 1;
      end
    end
    dr1 <= dl1;
  end

  xilinx_fifo_sync_reader #(
    .DATA_WIDTH(DW), .DO_REG(0)
  ) u_dut0 (
    .CLK(clk), .RST(rst),
    .FIFO_EMPTY(e0), .FIFO_DO(do0),
    .FIFO_RDERR(re0), .FIFO_RDEN(rden0),
    .M_VALID(v0), .M_READY(rdy0),
    .M_DATA(md0), .OCCUPANCY(oc0),
    .RDERR_STICKY(st0)
  );

  xilinx_fifo_sync_reader #(
    .DATA_WIDTH(DW), .DO_REG(1)
  ) u_dut1 (
    .CLK(clk), .RST(rst),
    .FIFO_EMPTY(e1), .FIFO_DO(do1),
    .FIFO_RDERR(re1), .FIFO_RDEN(rden1),
    .M_VALID(v1), .M_READY(rdy1),
    .M_DATA(md1), .OCCUPANCY(oc1),
    .RDERR_STICKY(st1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wr_word(input int d,
                         input logic [DW-1:0] v);
    if (d == 0) begin
      fm0[wr0[5:0]] = v;
      wr0++;
      q0.push_back(v);
    end else begin
      fm1[wr1[5:0]] = v;
      wr1++;
      q1.push_back(v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && rdy0) begin
        if (q0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut0 stray word: got %0h expected none",
                   md0);
        end else begin
          chk("dut0 data", {24'd0, md0}, {24'd0, q0.pop_front()});
        end
      end
      if (v1 && rdy1) begin
        n_del1++;
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut1 stray word: got %0h expected none",
                   md1);
        end else begin
          chk("dut1 data", {24'd0, md1}, {24'd0, q1.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [15:0] h_r, h_v;
  logic        stable;
  int          base;

  initial begin
    rst = 1'b1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    force_err = 1'b0;
    wr0 = 0;
    wr1 = 0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst rden0", rden0, 0);
    chk("rst valid0", v0, 0);
    chk("rst data0", md0, 0);
    chk("rst occ0", oc0, 0);
    chk("rst rden1", rden1, 0);
    chk("rst valid1", v1, 0);
    chk("rst occ1", oc1, 0);
    chk("rst sticky1", st1, 0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // L=1 streaming, ready held high
    rdy0 = 1'b1;
    h_r = '0;
    h_v = '0;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)
        for (int i = 1; i <= 8; i++) wr_word(0, DW'(i));
      @(negedge clk);
      h_r[k] = rden0;
      h_v[k] = v0;
      cyc();
    end
    chk("t1 rden pattern", h_r, 16'h00FF);
    chk("t1 valid pattern", h_v, 16'h03FC);
    chk("t1 drained", q0.size(), 0);
    chk("t1 sticky0", st0, 0);

    // L=2 backpressure then release
    rdy1 = 1'b0;
    h_r = '0;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)
        for (int i = 1; i <= 10; i++) wr_word(1, DW'(i));
      @(negedge clk);
      h_r[k] = rden1;
      if (v1 && md1 !== 8'h01) stable = 1'b0;
      cyc();
    end
    chk("t2 rden pulses", h_r, 16'h0007);
    chk("t2 occupancy", oc1, 3);
    chk("t2 valid", v1, 1);
    chk("t2 head", md1, 8'h01);
    chk("t2 head stable", stable, 1);
    rdy1 = 1'b1;
    h_v = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      h_v[k] = v1;
      cyc();
    end
    chk("t2 back-to-back", h_v, 16'h03FF);
    chk("t2 drained", q1.size(), 0);

    // L=2 ready toggling
    base = n_del1;
    for (int i = 1; i <= 20; i++) wr_word(1, DW'(i));
    for (int k = 0; k < 80 && q1.size() != 0; k++) begin
      rdy1 = (k % 2 == 0);
      cyc();
    end
    rdy1 = 1'b0;
    chk("t3 drained", q1.size(), 0);
    chk("t3 delivered", n_del1 - base, 20);
    chk("t3 sticky1", st1, 0);
    repeat (4) cyc();

    // FIFO runs empty after word 5, refilled 4 cycles later
    rdy1 = 1'b1;
    h_r = '0;
    h_v = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0)
        for (int i = 1; i <= 5; i++) wr_word(1, DW'(8'h40 + i));
      if (k == 9)
        for (int i = 6; i <= 8; i++) wr_word(1, DW'(8'h40 + i));
      @(negedge clk);
      h_r[k] = rden1;
      h_v[k] = v1;
      cyc();
    end
    chk("t4 rden pattern", h_r, 16'h0E1F);
    chk("t4 valid pattern", h_v, 16'h70F8);
    chk("t4 drained", q1.size(), 0);

    // reset with words buffered and a read in flight
    rdy1 = 1'b0;
    for (int i = 1; i <= 10; i++) wr_word(1, DW'(8'h50 + i));
    repeat (4) cyc();
    chk("t5 occ before reset", oc1, 2);
    rst = 1'b1;
    wr0 = 0;
    wr1 = 0;
    q0.delete();
    q1.delete();
    #1;
    chk("t5 valid in reset", v1, 0);
    chk("t5 rden in reset", rden1, 0);
    chk("t5 occ in reset", oc1, 0);
    chk("t5 data in reset", md1, 0);
    repeat (2) cyc();
    rst = 1'b0;
    rdy1 = 1'b1;
    h_v = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      h_v[k] = v1;
      cyc();
    end
    chk("t5 no stale data", h_v, 16'h0000);
    wr_word(1, 8'h61);
    wr_word(1, 8'h62);
    repeat (8) cyc();
    chk("t5 post-reset drained", q1.size(), 0);
    chk("t5 sticky0 clear", st0, 0);
    chk("t5 sticky1 clear", st1, 0);

    // one-cycle RDERR
    force_err = 1'b1;
    @(negedge clk);
    chk("t6 sticky before edge", st1, 0);
    cyc();
    force_err = 1'b0;
    @(negedge clk);
    chk("t6 sticky set", st1, 1);
    repeat (3) cyc();
    chk("t6 sticky held", st1, 1);
    chk("t6 sticky0 untouched", st0, 0);
    rst = 1'b1;
    #1;
    chk("t6 sticky cleared", st1, 0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
